// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, synchronizer depth and the
// packet start-of-frame byte. UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int         SYNC_DEPTH = 2;
  localparam logic [7:0] PKT_SOF    = 8'h8F;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Outcome of the stop-bit sample, turned into an output pulse one cycle later.
  typedef enum logic [1:0] {
    RES_NONE,
    RES_OK,
    RES_FRAME,
    RES_PARITY
  } rx_result_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {DEPTH{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver, 8N1 by default; defining UART_RX_PARITY_EN adds an
// even-parity bit between the data and stop bits.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter logic [15:0] CLKS_PER_BIT = 16'd868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx_pin,
  input  logic       uartDisabled,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_val,
  output logic       frame_err,
  output logic       parity_err
);

  if (CLKS_PER_BIT < 16'd4) begin : g_bad_clks_per_bit
    $fatal(1, "uart_byte_rx: CLKS_PER_BIT must be at least 4");
  end

  localparam logic [15:0] HALF_M1 = (CLKS_PER_BIT >> 1) - 16'd1;
  localparam logic [15:0] FULL_M1 = CLKS_PER_BIT - 16'd1;

  logic       rx_s;
  rx_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  rx_result_e res_q, res_d;
  logic [7:0] data_q;
  logic       val_q, ferr_q;

  uart_sync #(
    .DEPTH    (SYNC_DEPTH),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_ni(reset_n),
    .d_i   (uart_rx_pin),
    .q_o   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  logic perr_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    res_d   = RES_NONE;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    if (uartDisabled) begin
      state_d = RX_IDLE;
      cnt_d   = 16'd0;
      idx_d   = 3'd0;
    end else begin
      unique case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_d = RX_START;
            cnt_d   = HALF_M1;
          end
        end
        RX_START: begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else if (!rx_s) begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            idx_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end
        RX_DATA: begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            // LSB arrives first, so shift right and insert at the top.
            shift_d = {rx_s, shift_q[7:1]};
            cnt_d   = FULL_M1;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = RX_PARITY;
`else
              state_d = RX_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            par_err_d = (^shift_q) ^ rx_s;
            cnt_d     = FULL_M1;
            state_d   = RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else if (!rx_s) begin
            state_d = RX_BREAK;
            res_d   = RES_FRAME;
          end else begin
            state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
            res_d   = par_err_q ? RES_PARITY : RES_OK;
`else
            res_d   = RES_OK;
`endif
          end
        end
        RX_BREAK: begin
          if (rx_s) begin
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      res_q   <= res_d;
    end
  end

  // Output stage: pulses trail the stop-bit sample by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= 8'h00;
      val_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      val_q  <= !uartDisabled && (res_q == RES_OK);
      ferr_q <= !uartDisabled && (res_q == RES_FRAME);
      if (!uartDisabled && (res_q == RES_OK)) begin
        data_q <= shift_q;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
      perr_q    <= !uartDisabled && (res_q == RES_PARITY);
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign uart_rx_data = data_q;
  assign uart_rx_val  = val_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at 16 clocks per bit; honours
// UART_RX_PARITY_EN when it is defined for the build.
module tb_uart_byte_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + CPB;
`else
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif
  localparam logic [2:0] K_VAL = 3'b100;
  localparam logic [2:0] K_FRM = 3'b010;
  localparam logic [2:0] K_PAR = 3'b001;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
    logic [7:0] data;
  } ev_t;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       stop;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx_pin = 1'b1;
  logic       uartDisabled = 1'b0;
  logic [7:0] uart_rx_data;
  logic       uart_rx_val;
  logic       frame_err;
  logic       parity_err;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_data = 8'h00;
  ev_t        obs_q[$];
  ev_t        exp_q[$];

  uart_byte_rx #(.CLKS_PER_BIT(16'd16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .uart_rx_pin (uart_rx_pin),
    .uartDisabled(uartDisabled),
    .uart_rx_data(uart_rx_data),
    .uart_rx_val (uart_rx_val),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every output pulse is logged with the posedge count that produced it.
  always @(negedge clk) begin
    if (uart_rx_val === 1'b1 || frame_err === 1'b1 || parity_err === 1'b1)
      obs_q.push_back('{cyc, {uart_rx_val, frame_err, parity_err}, uart_rx_data});
  end

  function automatic frame_t mk_frame(input logic [7:0] b);
    return '{data: b, par: ^b, stop: 1'b1};
  endfunction

  // Reference model: a frame yields one event LAT edges after its start edge.
  function automatic void model_frame(input frame_t f, input int s);
    ev_t e;
    e.cyc  = s + LAT;
    e.data = f.data;
    if (!f.stop) e.kind = K_FRM;
`ifdef UART_RX_PARITY_EN
    else if ((^f.data) ^ f.par) e.kind = K_PAR;
`endif
    else begin
      e.kind    = K_VAL;
      last_data = f.data;
    end
    exp_q.push_back(e);
  endfunction

  task automatic send_frame(input frame_t f, output int s);
    uart_rx_pin = 1'b0;
    s = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_pin = f.data[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx_pin = f.par;
    repeat (CPB) @(negedge clk);
`endif
    uart_rx_pin = f.stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input frame_t f);
    int s;
    send_frame(f, s);
    model_frame(f, s);
  endtask

  task automatic idle(input int n);
    uart_rx_pin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (uart_rx_data !== 8'h00) begin n_err++; $display("FAIL reset.data: got %h want 00", uart_rx_data); end
    if (uart_rx_val !== 1'b0) begin n_err++; $display("FAIL reset.val: got %b want 0", uart_rx_val); end
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset.ferr: got %b want 0", frame_err); end
    if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset.perr: got %b want 0", parity_err); end
    reset_n = 1'b1;
    idle(5);
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL reset.idle_events: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_single;
    obs_q.delete(); exp_q.delete();
    send(mk_frame(8'hA5));
    idle(6);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL single.count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].kind !== exp_q[i].kind || (exp_q[i].kind == K_VAL && obs_q[i].data !== exp_q[i].data)) begin
        n_err++; $display("FAIL single.ev%0d: got cyc=%0d kind=%b data=%h want cyc=%0d kind=%b data=%h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
      end
    end
    n_cmp++;
    if (uart_rx_data !== 8'hA5) begin n_err++; $display("FAIL single.data: got %h want a5", uart_rx_data); end
  endtask

  task automatic test_back_to_back;
    obs_q.delete(); exp_q.delete();
    send(mk_frame(8'h8F));
    send(mk_frame(8'h01));
    send(mk_frame(8'h00));
    idle(6);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b.count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].kind !== exp_q[i].kind || (exp_q[i].kind == K_VAL && obs_q[i].data !== exp_q[i].data)) begin
        n_err++; $display("FAIL b2b.ev%0d: got cyc=%0d kind=%b data=%h want cyc=%0d kind=%b data=%h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
      end
    end
    n_cmp++;
    if (uart_rx_data !== last_data) begin n_err++; $display("FAIL b2b.data: got %h want %h", uart_rx_data, last_data); end
  endtask

  task automatic test_random;
    frame_t f;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      f.data = 8'($urandom);
      f.stop = ($urandom_range(0, 3) != 0);
      f.par  = (^f.data) ^ ($urandom_range(0, 3) == 0);
      send(f);
      if (!f.stop) idle(20 + $urandom_range(0, 10));
      else idle($urandom_range(0, 5));
    end
    idle(6);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL random.count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].kind !== exp_q[i].kind || (exp_q[i].kind == K_VAL && obs_q[i].data !== exp_q[i].data)) begin
        n_err++; $display("FAIL random.ev%0d: got cyc=%0d kind=%b data=%h want cyc=%0d kind=%b data=%h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
      end
    end
    n_cmp++;
    if (uart_rx_data !== last_data) begin n_err++; $display("FAIL random.data: got %h want %h", uart_rx_data, last_data); end
  endtask

  task automatic test_glitch;
    obs_q.delete(); exp_q.delete();
    uart_rx_pin = 1'b0;
    repeat (5) @(negedge clk);
    // Next start edge lands 12 cycles after the glitch began.
    idle(7);
    send(mk_frame(8'hC3));
    idle(6);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL glitch.count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].kind !== exp_q[i].kind || (exp_q[i].kind == K_VAL && obs_q[i].data !== exp_q[i].data)) begin
        n_err++; $display("FAIL glitch.ev%0d: got cyc=%0d kind=%b data=%h want cyc=%0d kind=%b data=%h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
      end
    end
  endtask

  task automatic test_frame_err;
    frame_t f;
    obs_q.delete(); exp_q.delete();
    f = mk_frame(8'h3C);
    f.stop = 1'b0;
    send(f);
    repeat (40) @(negedge clk);
    idle(10);
    send(mk_frame(8'h55));
    idle(6);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL ferr.count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].kind !== exp_q[i].kind || (exp_q[i].kind == K_VAL && obs_q[i].data !== exp_q[i].data)) begin
        n_err++; $display("FAIL ferr.ev%0d: got cyc=%0d kind=%b data=%h want cyc=%0d kind=%b data=%h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
      end
    end
    n_cmp++;
    if (uart_rx_data !== 8'h55) begin n_err++; $display("FAIL ferr.data: got %h want 55", uart_rx_data); end
  endtask

  task automatic test_disable;
    int s;
    obs_q.delete(); exp_q.delete();
    fork
      send_frame(mk_frame(8'hFF), s);
      begin
        repeat (CPB * 5 + 4) @(negedge clk);
        uartDisabled = 1'b1;
        repeat (3) @(negedge clk);
        uartDisabled = 1'b0;
      end
    join
    idle(8);
    n_cmp += 2;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL disable.events: got %0d want 0", obs_q.size()); end
    if (uart_rx_data !== last_data) begin n_err++; $display("FAIL disable.hold: got %h want %h", uart_rx_data, last_data); end
    send(mk_frame(8'($urandom)));
    idle(6);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL disable.count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
        n_err++; $display("FAIL disable.ev%0d: got cyc=%0d kind=%b data=%h want cyc=%0d kind=%b data=%h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_mid;
    int s;
    obs_q.delete(); exp_q.delete();
    fork
      send_frame(mk_frame(8'hFF), s);
      begin
        repeat (CPB * 4 + 7) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    last_data = 8'h00;
    idle(8);
    n_cmp += 2;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL rstmid.events: got %0d want 0", obs_q.size()); end
    if (uart_rx_data !== 8'h00) begin n_err++; $display("FAIL rstmid.data: got %h want 00", uart_rx_data); end
    send(mk_frame(8'($urandom_range(1, 255))));
    idle(6);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid.count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
        n_err++; $display("FAIL rstmid.ev%0d: got cyc=%0d kind=%b data=%h want cyc=%0d kind=%b data=%h", i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int s;
    obs_q.delete(); exp_q.delete();
    send_frame('{data: 8'h07, par: 1'b1, stop: 1'b1}, s);
    idle(4);
    n_cmp += 3;
    if (obs_q.size() != 1) begin n_err++; $display("FAIL parity.ok_count: got %0d want 1", obs_q.size()); end
    else begin
      if (obs_q[0].cyc - s !== 171) begin n_err++; $display("FAIL parity.ok_lat: got %0d want 171", obs_q[0].cyc - s); end
      if (obs_q[0].kind !== K_VAL || obs_q[0].data !== 8'h07) begin n_err++; $display("FAIL parity.ok_ev: got kind=%b data=%h want kind=100 data=07", obs_q[0].kind, obs_q[0].data); end
    end
    obs_q.delete();
    send_frame('{data: 8'h07, par: 1'b0, stop: 1'b1}, s);
    idle(4);
    n_cmp += 2;
    if (obs_q.size() != 1 || obs_q[0].kind !== K_PAR || obs_q[0].cyc - s !== 171) begin
      n_err++; $display("FAIL parity.err_ev: got %0d events kind=%b want 1 event kind=001 at +171", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].kind : 3'b000);
    end
    if (uart_rx_data !== 8'h07) begin n_err++; $display("FAIL parity.hold: got %h want 07", uart_rx_data); end
    last_data = 8'h07;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_glitch();
    test_frame_err();
    test_disable();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
